// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus responder.
//   - bus widths
//   - default decode window and timeout
//   - FSM state encoding
//   - address-window decode helper
package m68k_bus_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;

  localparam logic [23:0] DEF_BASE_ADDR  = 24'hF00000;
  localparam logic [23:0] DEF_ADDR_MASK  = 24'hFF0000;
  localparam int unsigned DEF_TIMEOUT    = 64;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IGNORE = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Word address A[23:1] against a byte-address base/mask; bit 0 never decodes.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] a,
                                    input logic [23:0]       base,
                                    input logic [23:0]       mask);
    return (a & mask[23:1]) == base[23:1];
  endfunction

endpackage

// File: rtl/m68k_bus_responder_sync2.sv
// Two-flop synchroniser for an asynchronous active-low strobe.
//   i_clk : fabric clock
//   i_rst : synchronous active-high reset, presets both flops to 1 (strobe idle)
//   i_d   : asynchronous input
//   o_q   : synchronised output
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 asynchronous-bus slave running on the fabric clock.
// Synchronises AS/UDS/LDS, decodes one address window, runs a REQ/ACK
// handshake to an internal peripheral and answers the CPU with DTACK_N,
// or BERR_N on timeout, held until the CPU releases AS.
//   CLK_IN, RESET          : fabric clock, synchronous active-high reset
//   AS_N, UDS_N, LDS_N     : asynchronous CPU strobes
//   RW, A, D_IN            : CPU direction, word address, write data
//   D_OUT, D_OE            : read data and pad output enable
//   DTACK_N, BERR_N        : CPU cycle termination
//   REQ, WE, ADDR, BE,
//   WDATA, ACK, RDATA      : peripheral handshake
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter logic [23:0] ADDR_MASK      = DEF_ADDR_MASK,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic              CLK_IN,
  input  logic              RESET,
  input  logic              AS_N,
  input  logic              UDS_N,
  input  logic              LDS_N,
  input  logic              RW,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D_IN,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_OE,
  output logic              DTACK_N,
  output logic              BERR_N,
  output logic              REQ,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [1:0]        BE,
  output logic [DATA_W-1:0] WDATA,
  input  logic              ACK,
  input  logic [DATA_W-1:0] RDATA
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic w_as_s;
  logic w_uds_s;
  logic w_lds_s;
  logic w_strobe;
  logic w_hit;
  logic w_timeout;

  logic [1:0]        r_state;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_oe;
  logic              r_dtack_n;
  logic              r_berr_n;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_be;
  logic [DATA_W-1:0] r_wdata;

  sync2 u_sync_as  (.i_clk(CLK_IN), .i_rst(RESET), .i_d(AS_N),  .o_q(w_as_s));
  sync2 u_sync_uds (.i_clk(CLK_IN), .i_rst(RESET), .i_d(UDS_N), .o_q(w_uds_s));
  sync2 u_sync_lds (.i_clk(CLK_IN), .i_rst(RESET), .i_d(LDS_N), .o_q(w_lds_s));

  assign w_strobe  = !w_as_s && (!w_uds_s || !w_lds_s);
  assign w_hit     = addr_hit(A, BASE_ADDR, ADDR_MASK);
  assign w_timeout = (r_cnt == TMO_LAST);

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_oe      <= 1'b0;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            if (w_hit) begin
              r_addr  <= A;
              r_we    <= ~RW;
              r_be    <= {~w_uds_s, ~w_lds_s};
              r_wdata <= D_IN;
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_BUSY;
            end else begin
              r_state <= ST_IGNORE;
            end
          end
        end
        ST_IGNORE: begin
          if (w_as_s) r_state <= ST_IDLE;
        end
        ST_BUSY: begin
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          // CPU abort outranks ACK; ACK outranks timeout.
          if (w_as_s) begin
            r_req   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (ACK) begin
            r_req     <= 1'b0;
            if (!r_we) r_dout <= RDATA;
            r_oe      <= ~r_we;
            r_dtack_n <= 1'b0;
            r_state   <= ST_DONE;
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_berr_n <= 1'b0;
            r_oe     <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          if (w_as_s) begin
            r_dtack_n <= 1'b1;
            r_berr_n  <= 1'b1;
            r_oe      <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign D_OUT   = r_dout;
  assign D_OE    = r_oe;
  assign DTACK_N = r_dtack_n;
  assign BERR_N  = r_berr_n;
  assign REQ     = r_req;
  assign WE      = r_we;
  assign ADDR    = r_addr;
  assign BE      = r_be;
  assign WDATA   = r_wdata;

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- FPGA-side slave/responder for the 68000 asynchronous bus; the CPU is the initiator and is clocked from the divided CPU clock.
- Runs on the fast fabric clock (40 MHz, two fabric cycles per CPU cycle).
- Synchronises AS/UDS/LDS, decodes one address window and runs a REQ/ACK transaction to an internal peripheral.
- Drives DTACK_N, or BERR_N on timeout, and holds it until the CPU releases AS.

Parameters:
- BASE_ADDR, 24'hF00000, window base; A[23:1] is compared with bit 0 ignored.
- ADDR_MASK, 24'hFF0000, a bit set in the mask takes part in the decode.
- TIMEOUT_CYCLES, 64, fabric cycles after REQ rises without ACK before BERR is asserted; range 2..255.

Ports:
- CLK_IN  in  1  fabric clock, 40 MHz
- RESET  in  1  synchronous, active-high reset
- AS_N  in  1  CPU address strobe, asynchronous
- UDS_N  in  1  upper data strobe, asynchronous
- LDS_N  in  1  lower data strobe, asynchronous
- RW  in  1  1=read, 0=write
- A  in  23  CPU address A[23:1]
- D_IN  in  16  CPU data bus, write direction
- D_OUT  out  16  read data to the CPU bus
- D_OE  out  1  read-data output enable for the pads
- DTACK_N  out  1  data transfer acknowledge, active low
- BERR_N  out  1  bus error, active low
- REQ  out  1  peripheral request
- WE  out  1  peripheral write enable, valid while REQ=1
- ADDR  out  23  latched word address
- BE  out  2  byte enables {upper, lower}
- WDATA  out  16  latched write data
- ACK  in  1  peripheral completion, single-cycle pulse
- RDATA  in  16  peripheral read data, valid while ACK=1

Behaviour:
- Reset values: D_OUT=0, D_OE=0, DTACK_N=1, BERR_N=1, REQ=0, WE=0, ADDR=0, BE=0, WDATA=0, state IDLE, timeout count 0, synchronisers preset to 1.
- Reset taken in any state, including mid-transaction, aborts it: all outputs return to reset values on the next edge.
- AS_N, UDS_N, LDS_N each pass through a 2-flop synchroniser giving as_s, uds_s, lds_s.
- A, RW and D_IN are sampled only when the synchronised strobes qualify them; they are not synchronised.
- State IDLE:
  - Strobe condition: as_s=0 and (uds_s=0 or lds_s=0).
  - Strobes met and (A & ADDR_MASK[23:1]) == BASE_ADDR[23:1]: latch ADDR=A, WE=~RW, BE={~uds_s,~lds_s}, WDATA=D_IN; set REQ=1; clear the counter; go to BUSY.
  - Strobes met, address outside the window: go to IGNORE, no outputs change.
- State IGNORE: wait for as_s=1, then go to IDLE. This prevents re-decode within one CPU cycle.
- State BUSY:
  - REQ stays high; the counter increments each cycle.
  - ACK=1: REQ=0, D_OUT=RDATA (reads only; writes leave D_OUT unchanged), D_OE=RW, DTACK_N=0; go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ACK: REQ=0, BERR_N=0, D_OE=0; go to DONE.
  - ACK in the same cycle as the timeout: ACK wins.
  - as_s=1 (CPU abort): REQ=0; go to IDLE; no DTACK or BERR. An ACK in that same cycle is ignored.
- State DONE:
  - Hold DTACK_N, BERR_N, D_OE and D_OUT.
  - When as_s=1: DTACK_N=1, BERR_N=1, D_OE=0 on the same edge; go to IDLE.
  - ACK pulses arriving in DONE or IDLE are ignored.
- Latency:
  - AS/DS pin low to REQ high: 3 CLK_IN cycles.
  - ACK to DTACK_N low: 1 cycle.
  - AS_N pin high to DTACK_N high: 3 cycles.
- DTACK_N and BERR_N are never both low.
- D_OE is never high while in IDLE or during a write.
- Counter width is 8 bits; the counter saturates and never wraps.

Decomposition:
- Shared package m68k_bus_pkg holds:
  - state encoding: IDLE, IGNORE, BUSY, DONE;
  - width constants: ADDR_W=23, DATA_W=16;
  - default window constants.
- Sub-module sync2: a 2-flop synchroniser with a preset-to-1 synchronous reset, instantiated three times, once per strobe.

Test Plan:
- Word read at A=23'h780000 (byte address F00000), UDS_N=LDS_N=0, RW=1; peripheral ACKs 2 cycles after REQ with RDATA=16'hBEEF:
  - REQ rises 3 cycles after the strobes; WE=0, BE=2'b11;
  - DTACK_N=0, D_OE=1, D_OUT=BEEF one cycle after ACK;
  - both release 3 cycles after AS_N goes high.
- Byte write at A=23'h780001, LDS_N=0 and UDS_N=1 asserted 1 cycle after AS_N, RW=0, D_IN=16'h00A5:
  - ADDR=780001, WE=1, BE=2'b01, WDATA=00A5;
  - D_OE stays 0; DTACK_N asserts after ACK.
- Read at A=23'h780010 with ACK never asserted:
  - BERR_N=0 exactly TIMEOUT_CYCLES after REQ rises; REQ=0; DTACK_N stays 1;
  - BERR_N clears after AS_N rises.
- Access at A=23'h000100 (outside the window):
  - REQ, DTACK_N and BERR_N never change;
  - the state returns to IDLE after AS_N rises;
  - a second in-window access then completes normally.
- AS_N deasserted while in BUSY, with ACK arriving in the same cycle the synchronised AS goes high: REQ drops, no DTACK_N pulse, back to IDLE.
- RESET asserted 1 cycle after DTACK_N goes low, with AS_N still low: next edge gives all outputs at reset values; state IGNORE is not entered wrongly; the next access works.
